regfile_param: RTL and testbench
================================

REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, entry width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W entries.
REQ-003 The block SHALL have parameter REG_READ, default 0, which selects the read mode: 0 = combinational reads, 1 = registered reads with 1-cycle latency.
REQ-004 The block SHALL have parameter ZERO_REG, default 0, which when 1 hardwires entry 0 to zero.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-007 The block SHALL have port clear, input, 1, a request to start the sequential clear sweep.
REQ-008 The block SHALL have port write_enable, input, 1, the write request for port W.
REQ-009 The block SHALL have port address_w, input, ADDR_W, the write address.
REQ-010 The block SHALL have port data_in_w, input, DATA_W, the write data.
REQ-011 The block SHALL have ports address_a and address_b, input, ADDR_W, the read addresses for ports A and B.
REQ-012 The block SHALL have ports data_out_a and data_out_b, output, DATA_W, the read data for ports A and B.
REQ-013 The block SHALL have port busy, output, 1, asserted while the clear sweep is active.
REQ-014 The block SHALL have port write_drop, output, 1, a one-cycle pulse flagging a write ignored because of busy.

Function
REQ-015 Write SHALL be accepted at a rising edge when write_enable=1, busy=0 and reset=0: entry[address_w] <= data_in_w.
REQ-016 With ZERO_REG=1, writes to address 0 SHALL be discarded silently (no write_drop), and reads of address 0 SHALL return 0.
REQ-017 Forwarding: when an accepted write targets the same address as a read port in the same cycle, that port SHALL return data_in_w, not the stale entry; addr 0 is excluded when ZERO_REG=1.
REQ-018 REG_READ=0: data_out_a/b SHALL be combinational functions of the address, the array contents and the forwarded write, with 0-cycle latency.
REQ-019 REG_READ=1: data_out_a/b SHALL be registered, sampling the REQ-017/018 value at each rising edge, for a latency of exactly 1 cycle.
REQ-020 The clear FSM SHALL have states IDLE and SWEEP, with a sweep counter cnt of ADDR_W bits.
REQ-021 In IDLE, clear=1 at a rising edge SHALL move the FSM to SWEEP with cnt=0; busy=1 from the next cycle.
REQ-022 Each SWEEP cycle SHALL zero entry[cnt] and increment cnt; when cnt=DEPTH-1 the FSM SHALL zero that entry and return to IDLE, so the sweep occupies exactly DEPTH cycles.
REQ-023 clear asserted during SWEEP SHALL be ignored: no restart and no extension.
REQ-024 write_enable during SWEEP SHALL not modify the array, and write_drop SHALL be 1 in the following cycle only.
REQ-025 A write accepted in the same IDLE cycle that clear is sampled SHALL be performed and then zeroed by the sweep.
REQ-026 Reads during SWEEP SHALL return current contents: entries below cnt read 0, and entries not yet swept keep their old values.
REQ-027 Priority at each edge SHALL be reset > sweep/clear > write.

Reset
REQ-028 On reset=1 at a rising edge, all DEPTH entries SHALL become 0 in that single cycle.
REQ-029 On reset, the FSM SHALL go to IDLE, cnt=0, busy=0 and write_drop=0, and for REG_READ=1 the output registers SHALL become 0.
REQ-030 Reset asserted mid-sweep SHALL abort the sweep, with busy=0 in the next cycle and all entries 0.
REQ-031 Writes and clear requests coincident with reset SHALL be ignored.

Verification
REQ-032 The bench SHALL cover this basic case: defaults, write 0xBEEF to addr 5, then read A=5 and B=5 -> both return 0xBEEF, and all other addresses return 0.
REQ-033 The bench SHALL cover this forwarding case: write 0x1234 to addr 3 while A=3 -> data_out_a=0x1234 the same cycle (REG_READ=0), or the next cycle (REG_READ=1).
REQ-034 The bench SHALL cover this sweep case: fill all 16 entries with 0xFFFF, then pulse clear -> busy high for exactly 16 cycles, and entry k reads 0 from sweep cycle k+1 onward.
REQ-035 The bench SHALL cover this dropped-write case: write 0xAAAA to addr 9 during SWEEP -> write_drop pulses 1 cycle, addr 9 reads 0 after the sweep, and a second clear mid-sweep does not extend busy.
REQ-036 The bench SHALL cover this abort case: reset at sweep cycle 6 -> busy=0 next cycle, and all entries read 0.
REQ-037 The bench SHALL cover this zero-register case: with ZERO_REG=1, DATA_W=32, ADDR_W=5, write 0xDEADBEEF to addr 0 -> reads 0 with no write_drop, while addr 31 stores the full 32-bit value.

Source files
------------

// File: rtl/regfile_param.sv
// Parameterised 2-read/1-write register file with write forwarding, optional
// registered reads, optional hardwired-zero entry 0 and a sequential clear sweep.
module regfile_param #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int REG_READ = 0,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] address_w,
  input  logic [DATA_W-1:0] data_in_w,
  input  logic [ADDR_W-1:0] address_a,
  input  logic [ADDR_W-1:0] address_b,
  output logic [DATA_W-1:0] data_out_a,
  output logic [DATA_W-1:0] data_out_b,
  output logic              busy,
  output logic              write_drop
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_zero;
  logic              wr_acc;
  logic [DATA_W-1:0] rd_a, rd_b;

  assign busy    = (state == SWEEP);
  assign wr_zero = (ZERO_REG != 0) && (address_w == '0);
  assign wr_acc  = write_enable && !busy && !reset && !wr_zero;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (clear) begin
          state_nxt = SWEEP;
          cnt_nxt   = '0;
        end
      end
      SWEEP: begin
        // cnt wraps back to 0 on the last entry, leaving it ready for the next sweep
        cnt_nxt = cnt + 1'b1;
        if (&cnt) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      write_drop <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      write_drop <= write_enable && busy;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (busy) begin
      mem[cnt] <= '0;
    end else if (wr_acc) begin
      mem[address_w] <= data_in_w;
    end
  end

  // Read value seen by a port: zero register, then same-cycle write, then the array
  function automatic logic [DATA_W-1:0] read_val(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    if ((ZERO_REG != 0) && (addr == '0)) begin
      val = '0;
    end else if (wr_acc && (address_w == addr)) begin
      val = data_in_w;
    end else begin
      val = mem[addr];
    end
    return val;
  endfunction

  always_comb begin
    rd_a = read_val(address_a);
    rd_b = read_val(address_b);
  end

  generate
    if (REG_READ != 0) begin : g_reg_read
      always_ff @(posedge clk) begin
        if (reset) begin
          data_out_a <= '0;
          data_out_b <= '0;
        end else begin
          data_out_a <= rd_a;
          data_out_b <= rd_b;
        end
      end
    end else begin : g_comb_read
      assign data_out_a = rd_a;
      assign data_out_b = rd_b;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: default, registered-read and zero-register
// instances share clock and reset; expected values are hand-computed constants.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        reset, clear, we;
  logic [3:0]  aw, aa, ab;
  logic [15:0] din;
  logic [15:0] a, b, rr_a, rr_b;
  logic        busy, drop, rr_busy, rr_drop;

  logic        z_clear, z_we;
  logic [4:0]  z_aw, z_aa, z_ab;
  logic [31:0] z_din, z_a, z_b;
  logic        z_busy, z_drop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_param u_dut (
    .clk(clk), .reset(reset), .clear(clear), .write_enable(we),
    .address_w(aw), .data_in_w(din), .address_a(aa), .address_b(ab),
    .data_out_a(a), .data_out_b(b), .busy(busy), .write_drop(drop)
  );

  regfile_param #(.REG_READ(1)) u_rr (
    .clk(clk), .reset(reset), .clear(clear), .write_enable(we),
    .address_w(aw), .data_in_w(din), .address_a(aa), .address_b(ab),
    .data_out_a(rr_a), .data_out_b(rr_b), .busy(rr_busy), .write_drop(rr_drop)
  );

  regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_zr (
    .clk(clk), .reset(reset), .clear(z_clear), .write_enable(z_we),
    .address_w(z_aw), .data_in_w(z_din), .address_a(z_aa), .address_b(z_ab),
    .data_out_a(z_a), .data_out_b(z_b), .busy(z_busy), .write_drop(z_drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; clear = 1'b0; we = 1'b0; aw = '0; din = '0; aa = '0; ab = '0;
    z_clear = 1'b0; z_we = 1'b0; z_aw = '0; z_din = '0; z_aa = '0; z_ab = '0;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop, 0);
    chk("rst_a", a, 0);
    chk("rst_rr_a", rr_a, 0);
    chk("rst_rr_b", rr_b, 0);
    chk("rst_rr_drop", rr_drop, 0);
    chk("rst_z_busy", z_busy, 0);
    tick();

    // basic write and read-back
    we = 1'b1; aw = 4'd5; din = 16'hBEEF;
    tick();
    we = 1'b0; aa = 4'd5; ab = 4'd5;
    @(negedge clk);
    chk("basic_a5", a, 16'hBEEF);
    chk("basic_b5", b, 16'hBEEF);
    tick();
    for (int i = 0; i < 16; i++) begin
      if (i != 5) begin
        aa = 4'(i); ab = 4'(i);
        @(negedge clk);
        chk("basic_other_a", a, 0);
        chk("basic_other_b", b, 0);
        tick();
      end
    end

    // forwarding: comb port sees the write now, registered port one cycle later
    we = 1'b1; aw = 4'd3; din = 16'h1234; aa = 4'd3; ab = 4'd7;
    @(negedge clk);
    chk("fwd_a", a, 16'h1234);
    chk("fwd_b_other", b, 0);
    chk("fwd_rr_a_before", rr_a, 0);
    tick();
    we = 1'b0;
    @(negedge clk);
    chk("fwd_rr_a_after", rr_a, 16'h1234);
    chk("fwd_a_stored", a, 16'h1234);
    tick();

    // fill, then clear with a coincident write to addr 4
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; aw = 4'(i); din = 16'hFFFF;
      tick();
    end
    we = 1'b1; aw = 4'd4; din = 16'h1234; clear = 1'b1; aa = '0;
    @(negedge clk);
    chk("clr_cycle_busy", busy, 0);
    tick();
    we = 1'b0; clear = 1'b0;
    for (int k = 0; k < 16; k++) begin
      aa = 4'(k);
      ab = 4'(k - 1);
      @(negedge clk);
      chk("sweep_busy", busy, 1);
      chk("sweep_unswept", a, (k == 4) ? 16'h1234 : 16'hFFFF);
      if (k > 0) chk("sweep_swept", b, 0);
      if (k == 0) chk("sweep_rr_busy", rr_busy, 1);
      tick();
    end
    aa = 4'd15; ab = 4'd4;
    @(negedge clk);
    chk("sweep_end_busy", busy, 0);
    chk("sweep_end_a15", a, 0);
    chk("sweep_end_b4", b, 0);
    tick();

    // dropped write and ignored second clear during a sweep
    we = 1'b1; aw = 4'd9; din = 16'h5555;
    tick();
    we = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int c = 0; c < 16; c++) begin
      aa = 4'd9; aw = 4'd9; din = 16'hAAAA;
      we = (c == 2);
      clear = (c == 5);
      @(negedge clk);
      chk("drop_busy", busy, 1);
      chk("drop_pulse", drop, (c == 3) ? 1 : 0);
      chk("drop_a9", a, (c <= 9) ? 16'h5555 : 16'h0000);
      tick();
    end
    we = 1'b0; clear = 1'b0;
    @(negedge clk);
    chk("drop_no_extend", busy, 0);
    chk("drop_a9_after", a, 0);
    chk("drop_after", drop, 0);
    tick();

    // reset at sweep cycle 6, with write and clear coincident
    we = 1'b1; aw = 4'd12; din = 16'h7777;
    tick();
    we = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    aa = 4'd12; reset = 1'b1; we = 1'b1; aw = 4'd1; din = 16'h9999; clear = 1'b1;
    @(negedge clk);
    chk("abort_busy_pre", busy, 1);
    chk("abort_a12_pre", a, 16'h7777);
    tick();
    reset = 1'b0; we = 1'b0; clear = 1'b0;
    @(negedge clk);
    chk("abort_busy_post", busy, 0);
    chk("abort_a12_post", a, 0);
    chk("abort_rr_a", rr_a, 0);
    chk("abort_drop", drop, 0);
    tick();
    for (int i = 0; i < 16; i++) begin
      aa = 4'(i); ab = 4'(i);
      @(negedge clk);
      chk("abort_all_zero", a, 0);
      chk("abort_idle", busy, 0);
      tick();
    end

    // zero-register instance, 32-bit data, 32 entries
    z_we = 1'b1; z_aw = 5'd0; z_din = 32'hDEADBEEF; z_aa = 5'd0; z_ab = 5'd31;
    @(negedge clk);
    chk("zr_a0_nofwd", z_a, 0);
    tick();
    z_we = 1'b0;
    @(negedge clk);
    chk("zr_drop", z_drop, 0);
    chk("zr_a0", z_a, 0);
    chk("zr_b31_empty", z_b, 0);
    tick();
    z_we = 1'b1; z_aw = 5'd31; z_din = 32'hDEADBEEF;
    @(negedge clk);
    chk("zr_b31_fwd", z_b, 32'hDEADBEEF);
    tick();
    z_we = 1'b0;
    @(negedge clk);
    chk("zr_b31", z_b, 32'hDEADBEEF);
    chk("zr_a0_after", z_a, 0);
    chk("zr_drop_after", z_drop, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
